// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor. Operands are processed LSB-first, one bit per
// clock, through a single full-subtract stage. The borrow between bits is kept
// in a flop. A start/busy/done handshake frames each job:
//   - a start seen in IDLE captures the operands,
//   - busy is high for WIDTH cycles,
//   - done pulses for one cycle in the cycle where diff/borrow_out update.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : job request, sampled only while idle
//   a          : minuend, captured on the accepting edge
//   b          : subtrahend, captured on the accepting edge
//   borrow_in  : initial borrow into bit 0, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when the result registers update
//   diff       : a - b - borrow_in modulo 2^WIDTH (holds the last result)
//   borrow_out : borrow out of the MSB (1 when a < b + borrow_in, unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Full-subtract cell: returns {borrow_out, difference} for x - y - bi.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d_bit;
        logic b_bit;
        d_bit = x ^ y ^ bi;
        b_bit = (~x & y) | (~(x ^ y) & bi);
        return {b_bit, d_bit};
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [1:0]       cell_s;

    // Next-state logic for the datapath, FSM and result registers.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        cell_s  = full_sub(sa_q[0], sb_q[0], br_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                sr_d  = {cell_s[0], sr_q[WIDTH-1:1]};
                br_d  = cell_s[1];
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the full result in the same edge.
                    cnt_d   = '0;
                    diff_d  = {cell_s[0], sr_q[WIDTH-1:1]};
                    bout_d  = cell_s[1];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any running job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: last published result.
    logic [W-1:0] last_diff;
    logic         last_bo;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unsigned arithmetic reference: {borrow, diff}.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic [W:0] r;
        r = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        return r;
    endfunction

    // Runs one job from an idle DUT; optionally pulses start (a=8'h10) after sample ign_cyc.
    task automatic do_job(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int ign_cyc, input string tag);
        logic [W:0] e;
        e = ref_sub(av, bv, bi);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= W + 1; c++) begin
            if (c <= W) begin
                chk({tag, "_busy"}, busy, 1'b1);
                chk({tag, "_nodone"}, done, 1'b0);
                chk({tag, "_hold"}, {borrow_out, diff}, {last_bo, last_diff});
            end else begin
                chk({tag, "_busyfall"}, busy, 1'b0);
                chk({tag, "_done"}, done, 1'b1);
                chk({tag, "_diff"}, diff, e[W-1:0]);
                chk({tag, "_bout"}, borrow_out, e[W]);
            end
            if (c == ign_cyc) begin
                start = 1'b1; a = 8'h10; b = 8'h00; borrow_in = 1'b0;
            end else begin
                start = 1'b0; a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
            end
            @(negedge clk);
        end
        last_diff = e[W-1:0];
        last_bo   = e[W];
        chk({tag, "_donefall"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_keep"}, {borrow_out, diff}, {last_bo, last_diff});
    endtask

    initial begin
        logic [W:0] e;
        logic [W:0] expq[$];
        int cyc, ndone, last_done;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        last_diff = '0; last_bo = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", borrow_out, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Directed jobs.
        do_job(8'h05, 8'h03, 1'b0, 0, "j05m03");
        do_job(8'h03, 8'h05, 1'b0, 0, "j03m05");
        do_job(8'h00, 8'h00, 1'b1, 0, "j00m00b");
        do_job(8'hFF, 8'hFF, 1'b1, 0, "jFFmFFb");
        do_job(8'h80, 8'h01, 1'b0, 3, "ignore");

        // Reset in the middle of a job.
        a = 8'h55; b = 8'h22; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_diff", diff, 8'h00);
        chk("mid_rst_bout", borrow_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = '0; last_bo = 1'b0;
        @(negedge clk);
        do_job(8'h0A, 8'h0A, 1'b0, 0, "after_rst");

        // Random jobs.
        for (int i = 0; i < 6; i++) begin
            do_job(W'($urandom), W'($urandom), 1'($urandom), 0, "rand");
        end

        // Back-to-back with start held high, new operands in each done cycle.
        cyc = 0; ndone = 0; last_done = 0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        expq.push_back(ref_sub(a, b, borrow_in));
        start = 1'b1;
        while (ndone < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                e = expq.pop_front();
                chk("b2b_diff", diff, e[W-1:0]);
                chk("b2b_bout", borrow_out, e[W]);
                if (ndone == 1) chk("b2b_first_lat", cyc, W + 1);
                else            chk("b2b_spacing", cyc - last_done, W + 1);
                last_done = cyc;
                if (ndone < 3) begin
                    a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
                    expq.push_back(ref_sub(a, b, borrow_in));
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("b2b_count", ndone, 3);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
